// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider: one quotient bit per RUN cycle, start/done handshake.
// Defining DIV_SIGNED_EN adds the op_signed port and two's-complement operation.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             op_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             op_sgn;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] p_new;
  logic [WIDTH-1:0] q_new;

`ifdef DIV_SIGNED_EN
  assign op_sgn = op_signed;
`else
  assign op_sgn = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    shifted     = '0;
    trial       = '0;
    p_new       = '0;
    q_new       = '0;

    if (state_q == S_RUN) begin
      // Shift in the next dividend bit; a borrow out of the trial subtract means restore.
      shifted = {p_q, q_q[WIDTH-1]};
      trial   = {1'b0, shifted} - {2'b00, d_q};
      p_new   = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      q_new   = {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
      p_d     = p_new;
      q_d     = q_new;
      if (cnt_q == '0) begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        quotient_d  = apply_sign(q_new, quo_neg_q);
        remainder_d = apply_sign(p_new, rem_neg_q);
      end else begin
        cnt_d  = cnt_q - CW'(1);
        busy_d = 1'b1;
      end
    end else if (start) begin
      quotient_d  = '0;
      remainder_d = '0;
      dbz_d       = 1'b0;
      quo_neg_d   = op_sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      rem_neg_d   = op_sgn && dividend[WIDTH-1];
      if (divisor == '0) begin
        state_d     = S_DONE;
        done_d      = 1'b1;
        quotient_d  = '1;
        remainder_d = dividend;
        dbz_d       = 1'b1;
      end else begin
        state_d = S_RUN;
        busy_d  = 1'b1;
        cnt_d   = CW'(WIDTH - 1);
        p_d     = '0;
        q_d     = magnitude(dividend, op_sgn);
        d_d     = magnitude(divisor, op_sgn);
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: cycle-level arithmetic model plus directed literal cases.
module tb_seq_restoring_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  bit           op_sgn = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .op_signed(op_sgn),
`endif
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer division, truncating toward zero when signed.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
    longint sa, sb;
    z = 1'b0;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa == -64'sd2147483648 && sb == -1) begin
        q = 32'h8000_0000; r = '0;
      end else begin
        q = W'(sa / sb); r = W'(sa % sb);
      end
    end
  endfunction

  // Model of what the outputs must show in the current cycle.
  bit           m_busy = 0, m_done = 0, m_z = 0, p_z;
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_z = 0; m_left = 0; m_q = '0; m_r = '0;
    end
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("quotient", {32'd0, quotient}, {32'd0, m_q});
    chk("remainder", {32'd0, remainder}, {32'd0, m_r});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, m_z});
    if (rst_n) begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_z = p_z;
        end
      end else if (start) begin
        ref_div(dividend, divisor, op_sgn, p_q, p_r, p_z);
        m_q = '0; m_r = '0; m_z = 0;
        if (divisor == 0) begin
          m_done = 1; m_q = p_q; m_r = p_r; m_z = p_z;
        end else begin
          m_busy = 1; m_left = W;
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, output int e_cyc);
    start = 1'b1; dividend = a; divisor = b; op_sgn = s;
    @(posedge clk); #1;
    e_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic collect(input int e_cyc, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input bit ez, input int elat, input string nm, input bit chk_after);
    bit seen = 0;
    int lat = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; lat = cyc - e_cyc; end
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({nm, "_latency"}, 64'(lat), 64'(elat));
      chk({nm, "_q"}, {32'd0, quotient}, {32'd0, eq});
      chk({nm, "_r"}, {32'd0, remainder}, {32'd0, er});
      chk({nm, "_dbz"}, {63'd0, div_by_zero}, {63'd0, ez});
      if (chk_after) begin
        @(negedge clk);
        chk({nm, "_busy_after"}, {63'd0, busy}, 64'd0);
        chk({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
      end
    end
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez,
                         input int elat, input string nm);
    int e;
    @(posedge clk); #1;
    launch(a, b, s, e);
    collect(e, eq, er, ez, elat, nm, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_q", {32'd0, quotient}, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;

    run_job(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W, "t1_100div7");
    run_job(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, "t2_div0");

    // Back-to-back: the second start is presented during the done cycle of the first.
    @(posedge clk); #1;
    launch(32'hFFFF_FFFF, 32'd1, 1'b0, e);
    collect(e, 32'hFFFF_FFFF, 32'd0, 1'b0, W, "t3_max_div1", 1'b0);
    launch(32'd3, 32'd10, 1'b0, e);
    collect(e, 32'd0, 32'd3, 1'b0, W, "t3_b2b_3div10", 1'b1);

    // A start pulse while busy must be ignored.
    @(posedge clk); #1;
    launch(32'd1000, 32'd3, 1'b0, e);
    repeat (9) @(posedge clk);
    #1; start = 1'b1; dividend = 32'd9; divisor = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    collect(e, 32'd333, 32'd1, 1'b0, W, "t4_ignore_start", 1'b1);

    // Reset mid-run aborts with no done pulse.
    @(posedge clk); #1;
    launch(32'd1000, 32'd3, 1'b0, e);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_done", {63'd0, done}, 64'd0);
    chk("t5_rst_q", {32'd0, quotient}, 64'd0);
    chk("t5_rst_r", {32'd0, remainder}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job(32'd8, 32'd2, 1'b0, 32'd4, 32'd0, 1'b0, W, "t5_8div2");

`ifdef DIV_SIGNED_EN
    run_job(-32'sd7, 32'd2, 1'b1, -32'sd3, -32'sd1, 1'b0, W, "t6_m7div2");
    run_job(32'd7, -32'sd2, 1'b1, -32'sd3, 32'd1, 1'b0, W, "t6_7divm2");
    run_job(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, W, "t6_min_divm1");
    run_job(-32'sd9, 32'd0, 1'b1, 32'hFFFF_FFFF, -32'sd9, 1'b1, 0, "t6_sdiv0");
`endif

    // Random traffic: starts arrive at random, including while busy and in done cycles.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      dividend = $urandom;
      if ($urandom_range(0, 3) == 0) dividend = $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0: divisor = '0;
        1, 2: divisor = $urandom_range(1, 15);
        3: divisor = dividend;
        default: divisor = $urandom >> $urandom_range(0, 31);
      endcase
`ifdef DIV_SIGNED_EN
      op_sgn = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) begin
        dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF;
      end
`endif
    end
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
